tile_fetch: RTL



---
 rtl/tile_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/tile_fetch.sv
// tile_fetch: fetches the next 8-pixel tile column from map/pattern RAMs and serialises it to pixel.
// Latency: zero from hpos to pixel; the fetch runs one tile ahead, the shift register reloads on phase 7.
// Backpressure: none, timing slaved to hpos. Optional macro TILE_FETCH_SCROLL_EN adds the scroll_y port.
module tile_fetch #(
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525,
   parameter int MAP_A   = 10,
   parameter int PAT_A   = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [9:0]       hpos,
   input  logic [9:0]       vpos,
   input  logic             display_on,
   output logic [MAP_A-1:0] map_addr,
   input  logic [7:0]       map_dout,
   output logic [PAT_A-1:0] pat_addr,
   input  logic [7:0]       pat_dout,
`ifdef TILE_FETCH_SCROLL_EN
   input  logic [7:0]       scroll_y,
`endif
   output logic             pixel,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAP_WAIT,
      S_MAP_DATA,
      S_PAT_WAIT,
      S_PAT_DATA,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [MAP_A-1:0] r_map_addr;
   logic [PAT_A-1:0] r_pat_addr;
   logic [2:0]       r_line_lo;
   logic [7:0]       r_next_pat;
   logic [7:0]       r_shreg;

   logic [2:0]       w_phase;
   logic             w_last_grp;
   logic             w_last_line;
   logic [4:0]       w_col_n;
   logic [7:0]       w_line;
   logic [7:0]       w_eff_line;
   logic             w_ld_map;
   logic             w_ld_pat;
   logic             w_ld_next;

   assign w_phase     = hpos[2:0];
   assign w_last_grp  = (hpos == 10'(H_TOTAL - 8));
   assign w_last_line = (vpos == 10'(V_TOTAL - 1));

   // The last group of a line prefetches column 0 of the following line.
   assign w_col_n = w_last_grp ? 5'd0 : 5'(hpos[9:3] + 7'd1);
   assign w_line  = w_last_grp ? (w_last_line ? 8'd0 : vpos[7:0] + 8'd1) : vpos[7:0];

`ifdef TILE_FETCH_SCROLL_EN
   assign w_eff_line = w_line + scroll_y;
`else
   assign w_eff_line = w_line;
`endif

   // Next-state and load strobes; sequence after the start is unconditional so a skipping hpos cannot lock it up.
   always_comb begin
      w_state_nxt = r_state;
      w_ld_map    = 1'b0;
      w_ld_pat    = 1'b0;
      w_ld_next   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_phase == 3'd0) begin
               w_ld_map    = 1'b1;
               w_state_nxt = S_MAP_WAIT;
            end
         end
         S_MAP_WAIT: w_state_nxt = S_MAP_DATA;
         S_MAP_DATA: begin
            w_ld_pat    = 1'b1;
            w_state_nxt = S_PAT_WAIT;
         end
         S_PAT_WAIT: w_state_nxt = S_PAT_DATA;
         S_PAT_DATA: begin
            w_ld_next   = 1'b1;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (w_phase == 3'd7) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // RAM address registers, latched pattern row and the prefetched pattern byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_map_addr <= '0;
         r_pat_addr <= '0;
         r_line_lo  <= 3'd0;
         r_next_pat <= 8'd0;
      end else begin
         if (w_ld_map) begin
            r_map_addr <= MAP_A'({w_eff_line[7:3], w_col_n});
            r_line_lo  <= w_eff_line[2:0];
         end
         if (w_ld_pat)  r_pat_addr <= PAT_A'({map_dout, r_line_lo});
         if (w_ld_next) r_next_pat <= pat_dout;
      end
   end

   // Pixel shifter: reload at the end of phase 7 so the new tile starts exactly at phase 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_shreg <= 8'd0;
      else if (w_phase == 3'd7)  r_shreg <= r_next_pat;
      else                       r_shreg <= {r_shreg[6:0], 1'b0};
   end

   assign map_addr = r_map_addr;
   assign pat_addr = r_pat_addr;
   assign pixel    = r_shreg[7] & display_on;
   assign busy     = (r_state != S_IDLE);

endmodule
